// File: rtl/axil_regbank.sv
//==============================================================================
// Module   : axil_regbank
// Desc     : AXI4-Lite slave register bank with NUM_RW control and NUM_RO status
//            registers. Define AXIL_REGBANK_WSTRB_EN to enable byte-lane write strobes.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module axil_regbank #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           NUM_RW     = 4,
  parameter int unsigned           NUM_RO     = 4,
  parameter logic [DATA_WIDTH-1:0] RW_RESET   = '0
) (
  input  logic                                            ACLK,
  input  logic                                            ARESET,
  input  logic [ADDR_WIDTH-1:0]                           S_AXI_AWADDR,
  input  logic [2:0]                                      S_AXI_AWPROT,
  input  logic                                            S_AXI_AWVALID,
  output logic                                            S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]                           S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]                         S_AXI_WSTRB,
  input  logic                                            S_AXI_WVALID,
  output logic                                            S_AXI_WREADY,
  output logic [1:0]                                      S_AXI_BRESP,
  output logic                                            S_AXI_BVALID,
  input  logic                                            S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]                           S_AXI_ARADDR,
  input  logic [2:0]                                      S_AXI_ARPROT,
  input  logic                                            S_AXI_ARVALID,
  output logic                                            S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]                           S_AXI_RDATA,
  output logic [1:0]                                      S_AXI_RRESP,
  output logic                                            S_AXI_RVALID,
  input  logic                                            S_AXI_RREADY,
  output logic [NUM_RW*DATA_WIDTH-1:0]                    ctrl_out,
  output logic [NUM_RW-1:0]                               wr_pulse,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*DATA_WIDTH-1:0] status_in,
  output logic [((NUM_RO > 0) ? NUM_RO : 1)-1:0]          rd_pulse
);

  localparam int unsigned c_bytes  = DATA_WIDTH / 8;
  localparam int unsigned c_lsb    = $clog2(c_bytes);
  localparam int unsigned c_ro_w   = (NUM_RO > 0) ? NUM_RO : 1;
  localparam logic [1:0]  c_okay   = 2'b00;
  localparam logic [1:0]  c_slverr = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wstate_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  wstate_t               wstate_q, wstate_d;
  rstate_t               rstate_q, rstate_d;
  logic [DATA_WIDTH-1:0] ctrl_q [NUM_RW];
  logic [DATA_WIDTH-1:0] ctrl_d [NUM_RW];
  logic [1:0]            bresp_q, bresp_d;
  logic [NUM_RW-1:0]     wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [c_ro_w-1:0]     rd_pulse_q, rd_pulse_d;

  logic [31:0] w_aw_idx;
  logic [31:0] w_ar_idx;
  logic        w_wr_hs;
  logic        w_rd_hs;
  logic        w_aw_rw_hit;
  logic        w_ar_rw_hit;
  logic        w_ar_ro_hit;
  logic        w_unused;

  assign w_aw_idx    = 32'(S_AXI_AWADDR[ADDR_WIDTH-1:c_lsb]);
  assign w_ar_idx    = 32'(S_AXI_ARADDR[ADDR_WIDTH-1:c_lsb]);
  assign w_aw_rw_hit = (w_aw_idx < NUM_RW);
  assign w_ar_rw_hit = (w_ar_idx < NUM_RW);
  assign w_ar_ro_hit = !w_ar_rw_hit && (w_ar_idx < (NUM_RW + NUM_RO));

  // READY is gated by reset so nothing is handshaken while the bank is held in reset.
  assign w_wr_hs = (wstate_q == W_IDLE) && S_AXI_AWVALID && S_AXI_WVALID && !ARESET;
  assign w_rd_hs = (rstate_q == R_IDLE) && S_AXI_ARVALID && !ARESET;

  assign S_AXI_AWREADY = w_wr_hs;
  assign S_AXI_WREADY  = w_wr_hs;
  assign S_AXI_BVALID  = (wstate_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rstate_q == R_IDLE) && !ARESET;
  assign S_AXI_RVALID  = (rstate_q == R_DATA);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign wr_pulse      = wr_pulse_q;
  assign rd_pulse      = rd_pulse_q;

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_ctrl_out
    assign ctrl_out[gi*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[gi];
  end

`ifdef AXIL_REGBANK_WSTRB_EN
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[c_lsb-1:0], S_AXI_ARADDR[c_lsb-1:0]};
`else
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                      S_AXI_AWADDR[c_lsb-1:0], S_AXI_ARADDR[c_lsb-1:0]};
`endif

  always_comb begin
    wstate_d   = wstate_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    ctrl_d     = ctrl_q;
    case (wstate_q)
      W_IDLE: begin
        if (w_wr_hs) begin
          wstate_d = W_RESP;
          bresp_d  = w_aw_rw_hit ? c_okay : c_slverr;
          for (int i = 0; i < NUM_RW; i++) begin
            if (w_aw_idx == 32'(i)) begin
              wr_pulse_d[i] = 1'b1;
`ifdef AXIL_REGBANK_WSTRB_EN
              for (int k = 0; k < c_bytes; k++) begin
                if (S_AXI_WSTRB[k]) begin
                  ctrl_d[i][8*k +: 8] = S_AXI_WDATA[8*k +: 8];
                end
              end
`else
              ctrl_d[i] = S_AXI_WDATA;
`endif
            end
          end
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          wstate_d = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Reads sample ctrl_q, so a same-edge write to the same register returns the old value.
  always_comb begin
    rstate_d   = rstate_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_pulse_d = '0;
    case (rstate_q)
      R_IDLE: begin
        if (w_rd_hs) begin
          rstate_d = R_DATA;
          rdata_d  = '0;
          rresp_d  = (w_ar_rw_hit || w_ar_ro_hit) ? c_okay : c_slverr;
          for (int i = 0; i < NUM_RW; i++) begin
            if (w_ar_idx == 32'(i)) begin
              rdata_d = ctrl_q[i];
            end
          end
          for (int j = 0; j < NUM_RO; j++) begin
            if (w_ar_idx == 32'(NUM_RW + j)) begin
              rdata_d       = status_in[j*DATA_WIDTH +: DATA_WIDTH];
              rd_pulse_d[j] = 1'b1;
            end
          end
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate_q   <= W_IDLE;
      bresp_q    <= 2'b00;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_RW; i++) begin
        ctrl_q[i] <= RW_RESET;
      end
    end else begin
      wstate_q   <= wstate_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      for (int i = 0; i < NUM_RW; i++) begin
        ctrl_q[i] <= ctrl_d[i];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate_q   <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
      rd_pulse_q <= '0;
    end else begin
      rstate_q   <= rstate_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rd_pulse_q <= rd_pulse_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/axil_regbank.md
# axil_regbank

Parametrised AXI4-Lite slave register bank: the next generation of the 4-register S00_AXI slave in the TAR IP. It provides configurable data width, a configurable number of read/write control registers and read-only status registers, per-register write/read strobes, and SLVERR decoding of unmapped addresses. It sits between the PS AXI interconnect (or the master VIP in bench) and the TAR datapath control/status logic.

## Interface
Parameters:
- DATA_WIDTH, 32: AXI data width; 32 or 64 only.
- ADDR_WIDTH, 6: AXI byte address width; must satisfy 2^ADDR_WIDTH ≥ (NUM_RW+NUM_RO)·DATA_WIDTH/8.
- NUM_RW, 4: number of read/write control registers (1..16).
- NUM_RO, 4: number of read-only status registers (0..16).
- RW_RESET, 0: reset value of every RW register (DATA_WIDTH bits).

Ports:
- ACLK  in  1  single clock; all logic on its rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWPROT/AWVALID  in  ADDR_WIDTH/3/1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA/WSTRB/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR/ARPROT/ARVALID  in  ADDR_WIDTH/3/1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  DATA_WIDTH; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- ctrl_out  out  NUM_RW·DATA_WIDTH  RW register contents, register i in slice i.
- wr_pulse  out  NUM_RW  one-cycle strobe, bit i after a successful write to RW register i.
- status_in  in  NUM_RO·DATA_WIDTH  RO register sources, register j in slice j.
- rd_pulse  out  NUM_RO  one-cycle strobe, bit j after a read of RO register j (for clear-on-read in the consumer).

## Operation
- Word index = ADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low address bits are ignored; AxPROT is ignored.
- Index 0..NUM_RW-1 is RW register; NUM_RW..NUM_RW+NUM_RO-1 is RO register (j = index−NUM_RW); anything else is unmapped.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: AWREADY and WREADY both asserted for exactly one cycle, only when AWVALID and WVALID are both high. They are never accepted separately. On that edge, decode the address and go to W_RESP.
  - RW hit: register updated (see Configuration), BRESP=OKAY, wr_pulse[i]=1 for the next cycle.
  - RO hit or unmapped: no state change, BRESP=SLVERR (2'b10), no pulse.
  - W_RESP: BVALID held high with BRESP stable until BREADY, then back to W_IDLE. No new write is accepted in W_RESP.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1. On ARVALID, capture RDATA and go to R_DATA.
  - RW hit: current register value, RRESP=OKAY.
  - RO hit: status_in sampled at the handshake edge, RRESP=OKAY, rd_pulse[j]=1 for the next cycle.
  - Unmapped: RDATA=0, RRESP=SLVERR.
  - R_DATA: RVALID held with RDATA/RRESP stable until RREADY, then back to R_IDLE.
- Read and write FSMs are independent. A read and a write to the same RW register on the same edge: the read returns the pre-write value.
- Reset (any time, including mid-transaction): both FSMs go to IDLE; all VALID/READY outputs 0; RDATA=0; BRESP/RRESP=0; ctrl_out=RW_RESET; pulses 0. An in-flight transaction is dropped, and the master must re-issue it.

## Timing
- Write: AW/W handshake at edge N. BVALID and the updated ctrl_out are visible after edge N, and wr_pulse is high from edge N to edge N+1. Minimum write-to-write spacing is 2 cycles when BREADY is held high.
- Read: AR handshake at edge N. RVALID/RDATA are visible after edge N (1-cycle latency), and rd_pulse is high from edge N to edge N+1. Minimum 2 cycles per read when RREADY is held high.
- ARREADY is low throughout R_DATA. AWREADY/WREADY are low throughout W_RESP.

## Configuration
- AXIL_REGBANK_WSTRB_EN defined: byte lane k of the register is written only when WSTRB[k]=1. If all strobes are 0, the register is unchanged but the write still completes with OKAY and wr_pulse.
- Undefined: WSTRB is ignored and every RW hit writes the full word.

## Test plan
- Reset, then write 0x00000001..0x00000004 to offsets 0x0/0x4/0x8/0xC and read them back → OKAY, data matches, wr_pulse toggles once per write, ctrl_out slices equal 1..4.
- status_in slice 0 = 0xDEADBEEF, read offset 0x10 → RDATA=0xDEADBEEF, OKAY, rd_pulse[0] high for exactly 1 cycle. Write 0x5 to 0x10 → SLVERR, status unchanged, no pulse.
- Read offset 0x3C (unmapped) → RDATA=0, SLVERR. Write to 0x3C → SLVERR, no ctrl_out change.
- With WSTRB_EN: reg0=0x11223344, write 0xAABBCCDD with WSTRB=4'b0101 → reg0=0x11BB33DD. Without the macro → reg0=0xAABBCCDD.
- AWVALID asserted 3 cycles before WVALID, BREADY held low 5 cycles → AWREADY stays low until WVALID is high, BVALID is held 5 cycles, and no second write is accepted meanwhile.
- Assert ARESET while BVALID=1 and RVALID=1 → all outputs at reset values and ctrl_out=RW_RESET. After release, a fresh write/read completes normally.
